seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 113 +++++++++++
 tb/tb_seg_scan_driver.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-seg scanner (clk/rst in; data, dp_in, load, lz_en, bright in; dis_seg, dis_dp, upd_ack, frame out) with frame-synchronous update, zero blanking and PWM brightness
module seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                lz_en,
  input  logic [3:0]          bright,
  output logic [DIGITS+6:0]   dis_seg,
  output logic                dis_dp,
  output logic                upd_ack,
  output logic                frame
);
  localparam int CW = $clog2(DIV + 1);
  localparam int SW = $clog2(DIGITS);
  localparam int STEP = (DIV + 1) / 16;
  localparam logic [CW-1:0] CNT_END = CW'(DIV);
  localparam logic [SW-1:0] SEL_END = SW'(DIGITS - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic pend_q, pend_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS+6:0] dis_seg_q, dis_seg_d;
  logic dis_dp_q, dis_dp_d, upd_ack_q, upd_ack_d, frame_q, frame_d;
  logic cnt_end, wrap, lit, lz, blank, dp;
  logic [3:0] nib;
  logic [31:0] thr;
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'ha: seg7 = 7'b1110111;
      4'hb: seg7 = 7'b0011111;
      4'hc: seg7 = 7'b1001110;
      4'hd: seg7 = 7'b0111101;
      4'he: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction
  always_comb begin
    cnt_end = cnt_q == CNT_END;
    wrap = cnt_end && sel_q == SEL_END;
    cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
    sel_d = wrap ? '0 : sel_q + SW'(cnt_end);
    pend_d = !wrap && (load || pend_q);
    pend_data_d = load && !wrap ? data : pend_data_q;
    pend_dp_d = load && !wrap ? dp_in : pend_dp_q;
    act_data_d = !wrap ? act_data_q : load ? data : pend_q ? pend_data_q : act_data_q;
    act_dp_d = !wrap ? act_dp_q : load ? dp_in : pend_q ? pend_dp_q : act_dp_q;
    upd_ack_d = wrap && (load || pend_q);
    frame_d = wrap;
    nib = 4'h0;
    dp = 1'b0;
    blank = 1'b0;
    lz = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lz = lz && act_data_q[4*(DIGITS-1-i) +: 4] == 4'h0;
      if (sel_q == SW'(i)) begin
        nib = act_data_q[4*(DIGITS-1-i) +: 4];
        dp = act_dp_q[DIGITS-1-i];
        blank = lz_en && lz && i != DIGITS - 1;
      end
    end
    thr = 32'(STEP) * (32'(bright) + 32'd1);
    lit = bright == 4'hf || 32'(cnt_q) < thr;
    dis_seg_d = lit ? {{1'b1, {(DIGITS-1){1'b0}}} >> sel_q, blank ? 7'h0 : seg7(nib)} : '0;
    dis_dp_d = lit && dp;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
      pend_q <= 1'b0;
      pend_data_q <= '0;
      pend_dp_q <= '0;
      act_data_q <= '0;
      act_dp_q <= '0;
      dis_seg_q <= '0;
      dis_dp_q <= 1'b0;
      upd_ack_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      pend_q <= pend_d;
      pend_data_q <= pend_data_d;
      pend_dp_q <= pend_dp_d;
      act_data_q <= act_data_d;
      act_dp_q <= act_dp_d;
      dis_seg_q <= dis_seg_d;
      dis_dp_q <= dis_dp_d;
      upd_ack_q <= upd_ack_d;
      frame_q <= frame_d;
    end
  end
  assign dis_seg = dis_seg_q;
  assign dis_dp = dis_dp_q;
  assign upd_ack = upd_ack_q;
  assign frame = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized and directed checks of seg_scan_driver against a time-indexed display model
module tb_seg_scan_driver;
  localparam int D = 4;
  localparam int V = 15;
  localparam int SL = V + 1;
  localparam int FR = SL * D;
  localparam int STEP = SL / 16;
  localparam logic [6:0] SEG_T [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4*D-1:0] data = '0;
  logic [D-1:0] dp_in = '0;
  logic load = 1'b0;
  logic lz_en = 1'b0;
  logic [3:0] bright = 4'hf;
  logic [D+6:0] dis_seg;
  logic dis_dp, upd_ack, frame;
  int vec = 0;
  int bad = 0;
  int n;
  logic [4*D-1:0] sh_data, q_data;
  logic [D-1:0] sh_dp, q_dp;
  logic queued;
  logic [D+6:0] e_seg;
  logic e_dp, e_ack, e_frame;

  seg_scan_driver #(.DIGITS(D), .DIV(V)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .bright(bright), .dis_seg(dis_seg), .dis_dp(dis_dp), .upd_ack(upd_ack), .frame(frame)
  );

  always #5 clk = ~clk;

  // model: cycle n since reset fixes slot position; shown value changes only on frame boundaries
  always @(posedge clk or posedge rst) begin : model
    int c, s;
    logic [3:0] nb;
    logic bl;
    if (rst) begin
      n <= 0;
      sh_data <= '0;
      sh_dp <= '0;
      q_data <= '0;
      q_dp <= '0;
      queued <= 1'b0;
      e_seg <= '0;
      e_dp <= 1'b0;
      e_ack <= 1'b0;
      e_frame <= 1'b0;
    end else begin
      c = n % SL;
      s = (n / SL) % D;
      nb = 4'(sh_data >> (4 * (D - 1 - s)));
      bl = lz_en && s != D - 1 && (sh_data >> (4 * (D - 1 - s))) == 0;
      if (bright == 4'hf || c < STEP * (bright + 1)) begin
        e_seg <= {D'(1 << (D - 1 - s)), bl ? 7'd0 : SEG_T[nb]};
        e_dp <= sh_dp[D-1-s];
      end else begin
        e_seg <= '0;
        e_dp <= 1'b0;
      end
      e_frame <= n % FR == FR - 1;
      e_ack <= n % FR == FR - 1 && (load || queued);
      if (n % FR == FR - 1) begin
        queued <= 1'b0;
        if (load) begin
          sh_data <= data;
          sh_dp <= dp_in;
        end else if (queued) begin
          sh_data <= q_data;
          sh_dp <= q_dp;
        end
      end else if (load) begin
        queued <= 1'b1;
        q_data <= data;
        q_dp <= dp_in;
      end
      n <= n + 1;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({dis_seg, dis_dp, upd_ack, frame} !== 14'h0) begin
      bad++;
      $display("FAIL reset_hold got %b %b %b %b exp all zero", dis_seg, dis_dp, upd_ack, frame);
    end
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if ({dis_seg, dis_dp} !== {11'b1000_1111110, 1'b0}) begin
      bad++;
      $display("FAIL reset_first got %b/%b exp 10001111110/0", dis_seg, dis_dp);
    end
  endtask

  task automatic test_scan;
    logic [10:0] pat [4];
    pat[0] = 11'b1000_0110000;
    pat[1] = 11'b0100_1101101;
    pat[2] = 11'b0010_1110111;
    pat[3] = 11'b0001_1000111;
    data = 16'h12af;
    load = 1'b1;
    do begin
      @(negedge clk);
      load = 1'b0;
      vec++;
      if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame}) begin
        bad++;
        $display("FAIL scan_wait n=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", n, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
      end
    end while (n % FR != 0);
    vec++;
    if ({upd_ack, frame} !== 2'b11) begin
      bad++;
      $display("FAIL scan_ack got ack=%b frame=%b exp 1/1", upd_ack, frame);
    end
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      vec++;
      if (dis_seg !== pat[k/SL] || {dis_dp, upd_ack, frame} !== {e_dp, e_ack, e_frame}) begin
        bad++;
        $display("FAIL scan k=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", k, dis_seg, dis_dp, upd_ack, frame, pat[k/SL], e_dp, e_ack, e_frame);
      end
    end
  endtask

  task automatic test_handshake;
    int acks;
    repeat (20) begin
      @(negedge clk);
      vec++;
      if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame}) begin
        bad++;
        $display("FAIL hs_pre n=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", n, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
      end
    end
    data = 16'h0001;
    load = 1'b1;
    acks = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      if (n % FR != 0) acks += int'(upd_ack);
      vec++;
      if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame}) begin
        bad++;
        $display("FAIL hs_mid n=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", n, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
      end
    end while (n % FR != 0);
    vec++;
    if (acks != 0 || {upd_ack, frame} !== 2'b11) begin
      bad++;
      $display("FAIL hs_wrap early_acks=%0d ack=%b frame=%b exp 0/1/1", acks, upd_ack, frame);
    end
    acks = 0;
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k == 5) begin
        data = 16'h00a5;
        load = 1'b1;
      end
      if (k == 15) begin
        data = 16'h003c;
        load = 1'b1;
      end
      acks += int'(upd_ack);
      vec++;
      if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame}) begin
        bad++;
        $display("FAIL hs_two n=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", n, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
      end
    end
    vec++;
    if (acks != 1 || {upd_ack, frame} !== 2'b11) begin
      bad++;
      $display("FAIL hs_one_ack acks=%0d ack=%b frame=%b exp 1/1/1", acks, upd_ack, frame);
    end
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      vec++;
      if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame} ||
          (k >= 3 * SL && dis_seg[6:0] !== 7'b1001110)) begin
        bad++;
        $display("FAIL hs_show k=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", k, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
      end
    end
  endtask

  task automatic test_boundary;
    do begin
      @(negedge clk);
      vec++;
      if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame}) begin
        bad++;
        $display("FAIL bnd_wait n=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", n, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
      end
    end while (n % FR != FR - 1);
    data = 16'h7000;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    vec++;
    if ({upd_ack, frame} !== 2'b11) begin
      bad++;
      $display("FAIL bnd_ack got ack=%b frame=%b exp 1/1", upd_ack, frame);
    end
    @(negedge clk);
    vec++;
    if (dis_seg !== 11'b1000_1110000) begin
      bad++;
      $display("FAIL bnd_show got %b exp 10001110000", dis_seg);
    end
  endtask

  task automatic test_lz;
    logic [10:0] pat [2][4];
    logic [15:0] vals [2];
    pat[0] = '{11'b1000_0000000, 11'b0100_0000000, 11'b0010_0000000, 11'b0001_1111110};
    pat[1] = '{11'b1000_0000000, 11'b0100_0000000, 11'b0010_1011011, 11'b0001_1111110};
    vals[0] = 16'h0000;
    vals[1] = 16'h0050;
    lz_en = 1'b1;
    for (int v = 0; v < 2; v++) begin
      data = vals[v];
      load = 1'b1;
      do begin
        @(negedge clk);
        load = 1'b0;
        vec++;
        if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame}) begin
          bad++;
          $display("FAIL lz_wait n=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", n, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
        end
      end while (n % FR != 0);
      for (int k = 0; k < FR; k++) begin
        @(negedge clk);
        vec++;
        if (dis_seg !== pat[v][k/SL] || dis_seg !== e_seg) begin
          bad++;
          $display("FAIL lz v=%0d k=%0d got %b exp %b", v, k, dis_seg, pat[v][k/SL]);
        end
      end
    end
  endtask

  task automatic test_bright;
    logic [3:0] lv [2];
    lv[0] = 4'd3;
    lv[1] = 4'd0;
    lz_en = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bright = lv[b];
      for (int k = 0; k < FR; k++) begin
        @(negedge clk);
        vec++;
        if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame} ||
            ((n - 1) % SL <= int'(lv[b]) ? dis_seg[10:7] == 4'h0 : {dis_seg, dis_dp} != 12'h0)) begin
          bad++;
          $display("FAIL bright lvl=%0d cnt=%0d got %b/%b exp %b/%b", lv[b], (n - 1) % SL, dis_seg, dis_dp, e_seg, e_dp);
        end
      end
    end
    bright = 4'hf;
  endtask

  task automatic test_random;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      vec++;
      if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame}) begin
        bad++;
        $display("FAIL rand n=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", n, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
      end
      load = $urandom_range(19) == 0;
      if (load) begin
        data = 16'($urandom);
        dp_in = 4'($urandom);
      end
      if ($urandom_range(49) == 0) lz_en = 1'($urandom);
      if ($urandom_range(49) == 0) bright = 4'($urandom);
    end
    load = 1'b0;
    bright = 4'hf;
    lz_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    int acks;
    repeat (7) @(negedge clk);
    data = 16'hbeef;
    dp_in = 4'hf;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({dis_seg, dis_dp, upd_ack, frame} !== 14'h0) begin
      bad++;
      $display("FAIL rst_async got %b %b %b %b exp all zero", dis_seg, dis_dp, upd_ack, frame);
    end
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < FR + 20; k++) begin
      @(negedge clk);
      acks += int'(upd_ack);
      vec++;
      if ({dis_seg, dis_dp, upd_ack, frame} !== {e_seg, e_dp, e_ack, e_frame} ||
          (k == 0 && {dis_seg, dis_dp} !== {11'b1000_1111110, 1'b0})) begin
        bad++;
        $display("FAIL rst_after k=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", k, dis_seg, dis_dp, upd_ack, frame, e_seg, e_dp, e_ack, e_frame);
      end
    end
    vec++;
    if (acks != 0) begin
      bad++;
      $display("FAIL rst_no_ack acks=%0d exp 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_boundary();
    test_lz();
    test_bright();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
